// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register: DEPTH valid/ready stages of WIDTH bits that collapse bubbles.
// Define PIPE_REG_CHAIN_OCC_EN to add the registered occupancy output occ.
module pipe_reg_chain #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
`ifdef PIPE_REG_CHAIN_OCC_EN
  output logic [$clog2(DEPTH+1)-1:0] occ,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end

  // Handshake: a word moves across a boundary on a rising edge where valid and
  // ready are both 1. in_ready never looks at in_valid; out_valid and out_data
  // hold steady until out_ready takes them.
  logic             r_valid [DEPTH];
  logic [WIDTH-1:0] r_data  [DEPTH];
  logic             w_adv   [DEPTH];
  logic             w_src_valid [DEPTH];
  logic [WIDTH-1:0] w_src_data  [DEPTH];
  logic             w_push;
  logic             w_acc;

  // A stage may load when it is empty or when everything downstream moves.
  always_comb begin
    w_acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_acc    = w_acc | ~r_valid[i];
      w_adv[i] = w_acc;
    end
  end

  assign in_ready = w_adv[0] & ~flush;
  assign w_push   = in_valid & in_ready;

  assign w_src_valid[0] = w_push;
  assign w_src_data[0]  = in_data;
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_src
    assign w_src_valid[gi] = r_valid[gi-1];
    assign w_src_data[gi]  = r_data[gi-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= RST_VAL;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= w_src_valid[i];
          // Empty sources leave the old payload in place so no X ever flows.
          if (w_src_valid[i]) r_data[i] <= w_src_data[i];
        end
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic [OCC_W-1:0] r_occ;
  logic             w_pop;
  logic [DEPTH-1:0] w_valid_vec;

  assign w_pop = r_valid[DEPTH-1] & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_push & ~w_pop) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (~w_push & w_pop) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign occ = r_occ;

  for (genvar gv = 0; gv < DEPTH; gv++) begin : g_vvec
    assign w_valid_vec[gv] = r_valid[gv];
  end

`ifndef SYNTHESIS
  a_occ_matches_valid: assert property (@(posedge clk) disable iff (rst)
    r_occ == OCC_W'($countones(w_valid_vec)));
`endif
`endif

endmodule
